intr_flag_seq: RTL and testbench
================================

Name: intr_flag_seq

Overview:
- Interrupt entry/exit sequencer that drives the flag register's control interface: FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD and FLG_Z_LD.
- Synchronises and edge-detects the external interrupt line, counts pending requests, and holds the interrupt-enable bit.
- On interrupt entry it saves C/Z to the shadow flags; on RETIE it restores them.
- Sits between the external interrupt source, the control unit FSM and the flags block.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count on INTR_IN; minimum 2.
- CNT_W, 2, width of the pending-interrupt counter; saturates at 2^CNT_W-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- INTR_IN  in  1  external interrupt request, asynchronous, level.
- INSTR_DONE  in  1  control unit is at an instruction boundary (fetch state).
- I_SET  in  1  SEI instruction: set IE.
- I_CLR  in  1  CLI instruction: clear IE.
- RETIE  in  1  RETIE instruction executing.
- INT_TAKEN  out  1  one-cycle pulse telling the control unit to vector to the ISR.
- FLG_SHAD_LD  out  1  load shadow C/Z from live flags.
- FLG_LD_SEL  out  1  flag input mux: 0 = ALU, 1 = shadow.
- FLG_C_LD  out  1  load C flag (asserted only during restore).
- FLG_Z_LD  out  1  load Z flag (asserted only during restore).
- IE  out  1  interrupt enable bit.
- IN_ISR  out  1  high while servicing an interrupt (states ENTER, ISR, EXIT).
- PEND_CNT  out  CNT_W  pending request count.
- OVF  out  1  sticky: an edge arrived while PEND_CNT was saturated.
- SPUR_RETI  out  1  sticky: RETIE seen outside an ISR.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state=RUN; IE=0, PEND_CNT=0, OVF=0, SPUR_RETI=0.
  - Synchroniser and edge flops cleared.
  - All strobes 0.
  - Reset mid-ISR abandons the ISR; no restore strobes are issued.
- Synchroniser: INTR_IN passes through SYNC_STAGES flops plus one history flop.
  - rise = sync_out & ~hist.
  - PEND_CNT increments on the edge after rise is seen, i.e. the 3rd rising edge after INTR_IN goes high (SYNC_STAGES=2).
  - A level held high produces exactly one request.
- PEND_CNT arithmetic:
  - Increment on rise; decrement on leaving ENTER.
  - Both in the same cycle: count unchanged.
  - At max with an increment and no decrement: count holds and OVF sets.
  - Never decrements below 0.
- FSM states: RUN, ENTER, ISR, EXIT.
  - RUN -> ENTER when PEND_CNT!=0 & IE & INSTR_DONE; otherwise stay in RUN.
  - ENTER: exactly one cycle.
    - INT_TAKEN=1, FLG_SHAD_LD=1.
    - IE<=0 on exit.
    - PEND_CNT decrements.
    - Always goes to ISR.
  - ISR: stay until RETIE=1, then go to EXIT.
    - Further edges still count.
    - A new entry is impossible because IE=0, unless software executes SEI; even then, no nesting: the RUN->ENTER transition is only taken from RUN.
  - EXIT: exactly one cycle.
    - FLG_LD_SEL=1, FLG_C_LD=1, FLG_Z_LD=1.
    - IE<=1 on exit.
    - Goes to RUN.
    - A pending request may enter on the next qualifying RUN cycle (earliest 2 cycles after EXIT).
- IE updates:
  - In RUN/ISR: I_CLR has priority over I_SET; neither asserted holds IE.
  - ENTER forces IE<=0 and EXIT forces IE<=1, both overriding I_SET/I_CLR.
- Strobe rules:
  - Outside ENTER/EXIT: FLG_LD_SEL=0, FLG_SHAD_LD=0, FLG_C_LD=0, FLG_Z_LD=0.
  - The control unit ORs its own FLG_C_LD/FLG_Z_LD with these outputs.
  - All outputs are Moore, decoded from state and registers only.
- RETIE in RUN, ENTER or EXIT: no state change, no strobes; SPUR_RETI sets, and only when the RETIE arrives in RUN.

Test Plan:
1. RST=1 for 2 cycles, then release -> IE=0, PEND_CNT=0, state RUN, all strobes 0, OVF=0, SPUR_RETI=0.
2. I_SET pulse; INTR_IN high for 10 cycles; INSTR_DONE=1 -> PEND_CNT=1 at the 3rd edge; single ENTER cycle with INT_TAKEN=FLG_SHAD_LD=1; IE=0; PEND_CNT=0; IN_ISR=1.
3. From ISR, RETIE=1 for one cycle -> next cycle EXIT with FLG_LD_SEL=FLG_C_LD=FLG_Z_LD=1 for exactly 1 cycle; then RUN with IE=1.
4. IE=0; 4 separate INTR_IN pulses (CNT_W=2) -> PEND_CNT saturates at 3, OVF=1, no INT_TAKEN; then I_SET -> three ENTER/RETIE cycles; PEND_CNT ends at 0.
5. Rise coincides with the ENTER decrement at PEND_CNT=1 -> PEND_CNT stays 1; I_SET and I_CLR asserted together in RUN -> IE=0.
6. RETIE in RUN -> SPUR_RETI=1, no strobes; RST asserted during ISR -> RUN, IE=0, no restore strobes.

Source files
------------

// File: rtl/intr_flag_seq.sv
// Interrupt entry/exit sequencer: synchronises INTR_IN, counts pending requests,
// holds IE, and strobes the flag block to save C/Z on entry and restore them on RETIE.
module intr_flag_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INTR_IN,
  input  logic             INSTR_DONE,
  input  logic             I_SET,
  input  logic             I_CLR,
  input  logic             RETIE,
  output logic             INT_TAKEN,
  output logic             FLG_SHAD_LD,
  output logic             FLG_LD_SEL,
  output logic             FLG_C_LD,
  output logic             FLG_Z_LD,
  output logic             IE,
  output logic             IN_ISR,
  output logic [CNT_W-1:0] PEND_CNT,
  output logic             OVF,
  output logic             SPUR_RETI
);

  typedef enum logic [1:0] {S_RUN, S_ENTER, S_ISR, S_EXIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ie_q, ie_d;
  logic                   ovf_q, ovf_d;
  logic                   spur_q, spur_d;
  logic                   rise, inc, dec;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RUN;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      spur_q  <= spur_d;
    end
  end

  // Sync chain shifts toward the MSB; the history flop turns a held level into one rise.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], INTR_IN};
    hist_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_comb begin
    inc   = rise;
    dec   = (state_q == S_ENTER) && (cnt_q != '0);
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    spur_d  = spur_q;
    case (state_q)
      S_RUN: begin
        if ((cnt_q != '0) && ie_q && INSTR_DONE) state_d = S_ENTER;
        if (RETIE) spur_d = 1'b1;
        if (I_CLR)      ie_d = 1'b0;
        else if (I_SET) ie_d = 1'b1;
      end
      S_ENTER: begin
        state_d = S_ISR;
        ie_d    = 1'b0;
      end
      S_ISR: begin
        if (RETIE) state_d = S_EXIT;
        if (I_CLR)      ie_d = 1'b0;
        else if (I_SET) ie_d = 1'b1;
      end
      S_EXIT: begin
        state_d = S_RUN;
        ie_d    = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Moore outputs: the control unit ORs its own C/Z loads with the restore strobes.
  assign INT_TAKEN   = (state_q == S_ENTER);
  assign FLG_SHAD_LD = (state_q == S_ENTER);
  assign FLG_LD_SEL  = (state_q == S_EXIT);
  assign FLG_C_LD    = (state_q == S_EXIT);
  assign FLG_Z_LD    = (state_q == S_EXIT);
  assign IN_ISR      = (state_q != S_RUN);
  assign IE          = ie_q;
  assign PEND_CNT    = cnt_q;
  assign OVF         = ovf_q;
  assign SPUR_RETI   = spur_q;

endmodule

// File: tb/tb_intr_flag_seq.sv
// Bench for intr_flag_seq: table of {inputs, expected outputs} plus hand sequences,
// with expected output records queued at drive time and popped after each clock edge.
module tb_intr_flag_seq;

  logic       CLK = 1'b0;
  logic       RST, INTR_IN, INSTR_DONE, I_SET, I_CLR, RETIE;
  logic       INT_TAKEN, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, IE, IN_ISR, OVF, SPUR_RETI;
  logic [1:0] PEND_CNT;

  intr_flag_seq #(.SYNC_STAGES(2), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .INTR_IN(INTR_IN), .INSTR_DONE(INSTR_DONE),
    .I_SET(I_SET), .I_CLR(I_CLR), .RETIE(RETIE),
    .INT_TAKEN(INT_TAKEN), .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_LD_SEL(FLG_LD_SEL),
    .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .IE(IE), .IN_ISR(IN_ISR),
    .PEND_CNT(PEND_CNT), .OVF(OVF), .SPUR_RETI(SPUR_RETI)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rst, intr, done, iset, iclr, retie;
  } in_t;

  typedef struct packed {
    logic       taken, shad, sel, cld, zld, ie, isr, ovf, spur;
    logic [1:0] pend;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int RUN = 0, ENT = 1, ISR = 2, EXT = 3;

  int   n_cmp = 0;
  int   n_err = 0;
  out_t sb_q[$];
  vec_t tbl[$];

  function automatic in_t iv(logic rst, logic intr, logic done, logic iset, logic iclr, logic retie);
    in_t r;
    r = '{rst, intr, done, iset, iclr, retie};
    return r;
  endfunction

  // Expected Moore outputs for a given state plus the register values.
  function automatic out_t ex(int st, logic ie, int pend, logic ovf, logic spur);
    out_t r;
    r       = '0;
    r.taken = (st == ENT);
    r.shad  = (st == ENT);
    r.sel   = (st == EXT);
    r.cld   = (st == EXT);
    r.zld   = (st == EXT);
    r.isr   = (st != RUN);
    r.ie    = ie;
    r.ovf   = ovf;
    r.spur  = spur;
    r.pend  = 2'(pend);
    return r;
  endfunction

  task automatic step(input in_t i, input out_t e, input string tag);
    out_t exp_o, act_o;
    @(negedge CLK);
    RST = i.rst; INTR_IN = i.intr; INSTR_DONE = i.done;
    I_SET = i.iset; I_CLR = i.iclr; RETIE = i.retie;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    exp_o = sb_q.pop_front();
    act_o = '{INT_TAKEN, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, IE, IN_ISR, OVF, SPUR_RETI, PEND_CNT};
    n_cmp++;
    if (act_o !== exp_o) begin
      n_err++;
      $display("FAIL %s: got taken/shad/sel/cld/zld/ie/isr/ovf/spur/pend=%b required %b", tag, act_o, exp_o);
    end
  endtask

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  initial begin
    RST = 1'b1; INTR_IN = 1'b0; INSTR_DONE = 1'b0; I_SET = 1'b0; I_CLR = 1'b0; RETIE = 1'b0;

    // Reset, then single interrupt entry and RETIE exit.
    add(iv(1,0,0,0,0,0), ex(RUN,0,0,0,0));
    add(iv(1,0,0,0,0,0), ex(RUN,0,0,0,0));
    add(iv(0,0,0,1,0,0), ex(RUN,1,0,0,0));
    add(iv(0,1,1,0,0,0), ex(RUN,1,0,0,0));
    add(iv(0,1,1,0,0,0), ex(RUN,1,0,0,0));
    add(iv(0,1,1,0,0,0), ex(RUN,1,1,0,0));
    add(iv(0,1,1,0,0,0), ex(ENT,1,1,0,0));
    for (int k = 0; k < 6; k++) add(iv(0,1,1,0,0,0), ex(ISR,0,0,0,0));
    add(iv(0,0,1,0,0,0), ex(ISR,0,0,0,0));
    add(iv(0,0,1,0,0,1), ex(EXT,0,0,0,0));
    add(iv(0,0,1,0,0,0), ex(RUN,1,0,0,0));
    add(iv(0,0,1,0,0,0), ex(RUN,1,0,0,0));

    for (int k = 0; k < tbl.size(); k++) step(tbl[k].i, tbl[k].o, $sformatf("tbl%0d", k));

    // Saturation with IE clear, then three back-to-back services.
    step(iv(1,0,0,0,0,0), ex(RUN,0,0,0,0), "t4_rst");
    step(iv(0,0,1,0,1,0), ex(RUN,0,0,0,0), "t4_cli");
    for (int p = 0; p < 4; p++) begin
      int   prev, nw;
      logic ov;
      prev = (p > 3) ? 3 : p;
      nw   = (p + 1 > 3) ? 3 : p + 1;
      ov   = (p == 3);
      step(iv(0,1,1,0,0,0), ex(RUN,0,prev,0,0), $sformatf("t4_pulse%0d_a", p));
      step(iv(0,0,1,0,0,0), ex(RUN,0,prev,0,0), $sformatf("t4_pulse%0d_b", p));
      step(iv(0,0,1,0,0,0), ex(RUN,0,nw,ov,0),  $sformatf("t4_pulse%0d_c", p));
      step(iv(0,0,1,0,0,0), ex(RUN,0,nw,ov,0),  $sformatf("t4_pulse%0d_d", p));
    end
    step(iv(0,0,1,1,0,0), ex(RUN,1,3,1,0), "t4_sei");
    for (int k = 0; k < 3; k++) begin
      int pb;
      pb = 3 - k;
      step(iv(0,0,1,0,0,0), ex(ENT,1,pb,1,0),   $sformatf("t4_enter%0d", k));
      step(iv(0,0,1,0,0,0), ex(ISR,0,pb-1,1,0), $sformatf("t4_isr%0d", k));
      step(iv(0,0,1,0,0,1), ex(EXT,0,pb-1,1,0), $sformatf("t4_exit%0d", k));
      step(iv(0,0,1,0,0,0), ex(RUN,1,pb-1,1,0), $sformatf("t4_run%0d", k));
    end
    step(iv(0,0,1,0,0,0), ex(RUN,1,0,1,0), "t4_idle");

    // Rise coinciding with the ENTER decrement; SEI+CLI together.
    step(iv(1,0,0,0,0,0), ex(RUN,0,0,0,0), "t5_rst");
    step(iv(0,0,0,1,0,0), ex(RUN,1,0,0,0), "t5_sei");
    step(iv(0,1,0,0,0,0), ex(RUN,1,0,0,0), "t5_p1");
    step(iv(0,0,0,0,0,0), ex(RUN,1,0,0,0), "t5_p1b");
    step(iv(0,1,0,0,0,0), ex(RUN,1,1,0,0), "t5_p2");
    step(iv(0,0,1,0,0,0), ex(ENT,1,1,0,0), "t5_enter");
    step(iv(0,0,0,0,0,0), ex(ISR,0,1,0,0), "t5_cnt_hold");
    step(iv(0,0,0,0,0,1), ex(EXT,0,1,0,0), "t5_exit");
    step(iv(0,0,0,0,0,0), ex(RUN,1,1,0,0), "t5_run");
    step(iv(0,0,0,1,1,0), ex(RUN,0,1,0,0), "t5_clr_prio");

    // Spurious RETIE in RUN; reset during ISR issues no restore.
    step(iv(1,0,0,0,0,0), ex(RUN,0,0,0,0), "t6_rst");
    step(iv(0,0,0,0,0,1), ex(RUN,0,0,0,1), "t6_spur");
    step(iv(0,0,0,1,0,0), ex(RUN,1,0,0,1), "t6_sei");
    step(iv(0,1,0,0,0,0), ex(RUN,1,0,0,1), "t6_pa");
    step(iv(0,0,0,0,0,0), ex(RUN,1,0,0,1), "t6_pb");
    step(iv(0,0,0,0,0,0), ex(RUN,1,1,0,1), "t6_pc");
    step(iv(0,0,1,0,0,0), ex(ENT,1,1,0,1), "t6_enter");
    step(iv(0,0,0,0,0,0), ex(ISR,0,0,0,1), "t6_isr");
    step(iv(1,0,0,0,0,0), ex(RUN,0,0,0,0), "t6_rst_isr");
    step(iv(0,0,0,0,0,0), ex(RUN,0,0,0,0), "t6_after");
    step(iv(0,0,0,0,0,0), ex(RUN,0,0,0,0), "t6_after2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
